// File: rtl/ysyx_22050133_div_issue.sv
// Divider issue stage: accepts M-extension divide/remainder requests, resolves
// divide-by-zero and signed overflow locally, reuses the last divider result
// for repeated operands, and otherwise drives the multi-cycle divider.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      cancel any in-flight op
//   req_*                      request port (valid/ready, op, word, src1, src2, tag)
//   res_*                      result port (valid/ready, data, tag)
//   div_valid/div_ready        operand handshake to the divider
//   div_flush                  combinational cancel to the divider
//   divw/div_signed            divider op mode
//   dividend/divisor           effective (extended) operands to the divider
//   div_out_valid              divider result valid (level)
//   quotient/remainder         divider results
module ysyx_22050133_div_issue #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned TAG_W    = 5,
    parameter bit          REUSE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic             req_word,
    input  logic [XLEN-1:0]  req_src1,
    input  logic [XLEN-1:0]  req_src2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [XLEN-1:0]  res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             div_valid,
    input  logic             div_ready,
    output logic             div_flush,
    output logic             divw,
    output logic             div_signed,
    output logic [XLEN-1:0]  dividend,
    output logic [XLEN-1:0]  divisor,
    input  logic             div_out_valid,
    input  logic [XLEN-1:0]  quotient,
    input  logic [XLEN-1:0]  remainder
);

    localparam int unsigned WW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic             rem_q, rem_d;
    logic             word_q, word_d;
    logic             sgn_q, sgn_d;
    logic [XLEN-1:0]  src1_q, src1_d;
    logic [XLEN-1:0]  src2_q, src2_d;
    logic [XLEN-1:0]  dividend_q, dividend_d;
    logic [XLEN-1:0]  divisor_q, divisor_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             res_valid_q, res_valid_d;
    logic [XLEN-1:0]  res_data_q, res_data_d;
    logic             div_valid_q, div_valid_d;

    // Last-result reuse buffer
    logic             buf_vld_q, buf_vld_d;
    logic [XLEN-1:0]  buf_src1_q, buf_src1_d;
    logic [XLEN-1:0]  buf_src2_q, buf_src2_d;
    logic             buf_sgn_q, buf_sgn_d;
    logic             buf_word_q, buf_word_d;
    logic [XLEN-1:0]  buf_quo_q, buf_quo_d;
    logic [XLEN-1:0]  buf_rem_q, buf_rem_d;

    // W ops take the low word, extended according to signedness
    function automatic logic [XLEN-1:0] eff_op(input logic [XLEN-1:0] v,
                                               input logic word,
                                               input logic sgn);
        logic [XLEN-1:0] r;
        r = v;
        if (word) begin
            r = sgn ? {{(XLEN-WW){v[WW-1]}}, v[WW-1:0]}
                    : {{(XLEN-WW){1'b0}}, v[WW-1:0]};
        end
        return r;
    endfunction

    // Pick quotient or remainder; W results always sign-extend bit 31
    function automatic logic [XLEN-1:0] sel_res(input logic [XLEN-1:0] q,
                                                input logic [XLEN-1:0] r,
                                                input logic is_rem,
                                                input logic word);
        logic [XLEN-1:0] v;
        v = is_rem ? r : q;
        if (word) begin
            v = {{(XLEN-WW){v[WW-1]}}, v[WW-1:0]};
        end
        return v;
    endfunction

    // Request classification
    logic            req_sgn, req_rem;
    logic [XLEN-1:0] a_eff, b_eff, min_neg;
    logic            is_div0, is_ovf, is_hit, is_local;
    logic [XLEN-1:0] loc_quo, loc_rem;

    always_comb begin
        req_sgn  = ~req_op[0];
        req_rem  = req_op[1];
        a_eff    = eff_op(req_src1, req_word, req_sgn);
        b_eff    = eff_op(req_src2, req_word, req_sgn);
        min_neg  = req_word ? {{(XLEN-WW+1){1'b1}}, {(WW-1){1'b0}}}
                            : {1'b1, {(XLEN-1){1'b0}}};
        is_div0  = (b_eff == '0);
        is_ovf   = req_sgn && (a_eff == min_neg) && (b_eff == '1);
        is_hit   = REUSE_EN && buf_vld_q
                   && (buf_src1_q == req_src1) && (buf_src2_q == req_src2)
                   && (buf_sgn_q == req_sgn) && (buf_word_q == req_word);
        is_local = is_div0 || is_ovf || is_hit;
        loc_quo  = buf_quo_q;
        loc_rem  = buf_rem_q;
        if (is_div0) begin
            loc_quo = '1;
            loc_rem = a_eff;
        end else if (is_ovf) begin
            loc_quo = a_eff;
            loc_rem = '0;
        end
    end

    assign req_ready = (state_q == IDLE) && !flush;
    assign div_flush = flush && ((state_q == ISSUE) || (state_q == WAIT));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        word_d     = word_q;
        sgn_d      = sgn_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        tag_d      = tag_q;
        res_data_d = res_data_q;
        buf_vld_d  = buf_vld_q;
        buf_src1_d = buf_src1_q;
        buf_src2_d = buf_src2_q;
        buf_sgn_d  = buf_sgn_q;
        buf_word_d = buf_word_q;
        buf_quo_d  = buf_quo_q;
        buf_rem_d  = buf_rem_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        rem_d      = req_rem;
                        word_d     = req_word;
                        sgn_d      = req_sgn;
                        src1_d     = req_src1;
                        src2_d     = req_src2;
                        dividend_d = a_eff;
                        divisor_d  = b_eff;
                        tag_d      = req_tag;
                        if (is_local) begin
                            res_data_d = sel_res(loc_quo, loc_rem, req_rem, req_word);
                            state_d    = DONE;
                        end else begin
                            state_d = ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (div_ready) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (div_out_valid) begin
                        res_data_d = sel_res(quotient, remainder, rem_q, word_q);
                        buf_vld_d  = 1'b1;
                        buf_src1_d = src1_q;
                        buf_src2_d = src2_q;
                        buf_sgn_d  = sgn_q;
                        buf_word_d = word_q;
                        buf_quo_d  = quotient;
                        buf_rem_d  = remainder;
                        state_d    = DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        div_valid_d = (state_d == ISSUE);
        res_valid_d = (state_d == DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q       <= 1'b0;
            word_q      <= 1'b0;
            sgn_q       <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            tag_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            div_valid_q <= 1'b0;
            buf_vld_q   <= 1'b0;
            buf_src1_q  <= '0;
            buf_src2_q  <= '0;
            buf_sgn_q   <= 1'b0;
            buf_word_q  <= 1'b0;
            buf_quo_q   <= '0;
            buf_rem_q   <= '0;
        end else begin
            rem_q       <= rem_d;
            word_q      <= word_d;
            sgn_q       <= sgn_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            tag_q       <= tag_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            div_valid_q <= div_valid_d;
            buf_vld_q   <= buf_vld_d;
            buf_src1_q  <= buf_src1_d;
            buf_src2_q  <= buf_src2_d;
            buf_sgn_q   <= buf_sgn_d;
            buf_word_q  <= buf_word_d;
            buf_quo_q   <= buf_quo_d;
            buf_rem_q   <= buf_rem_d;
        end
    end

    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_tag    = tag_q;
    assign div_valid  = div_valid_q;
    assign divw       = word_q;
    assign div_signed = sgn_q;
    assign dividend   = dividend_q;
    assign divisor    = divisor_q;

endmodule

// File: tb/tb_ysyx_22050133_div_issue.sv
// Directed bench for ysyx_22050133_div_issue with a simple 3-cycle divider model.
module tb_ysyx_22050133_div_issue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_word;
    logic [63:0] req_src1;
    logic [63:0] req_src2;
    logic [4:0]  req_tag;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic [4:0]  res_tag;
    logic        div_valid;
    logic        div_ready;
    logic        div_flush;
    logic        divw;
    logic        div_signed;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        div_out_valid;
    logic [63:0] quotient;
    logic [63:0] remainder;

    ysyx_22050133_div_issue dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_word      (req_word),
        .req_src1      (req_src1),
        .req_src2      (req_src2),
        .req_tag       (req_tag),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_tag       (res_tag),
        .div_valid     (div_valid),
        .div_ready     (div_ready),
        .div_flush     (div_flush),
        .divw          (divw),
        .div_signed    (div_signed),
        .dividend      (dividend),
        .divisor       (divisor),
        .div_out_valid (div_out_valid),
        .quotient      (quotient),
        .remainder     (remainder)
    );

    always #5 clk = ~clk;

    // Divider model: 3 cycles busy after each accepted operand pair
    logic        m_busy;
    int          m_cnt;
    logic [63:0] m_q, m_r;
    assign div_ready     = ~m_busy;
    assign div_out_valid = ~m_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy    <= 1'b0;
            m_cnt     <= 0;
            m_q       <= '0;
            m_r       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (div_flush) begin
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy    <= 1'b0;
                quotient  <= m_q;
                remainder <= m_r;
            end
            m_cnt <= m_cnt - 1;
        end else if (div_valid) begin
            m_busy <= 1'b1;
            m_cnt  <= 3;
            if (div_signed) begin
                m_q <= $unsigned($signed(dividend) / $signed(divisor));
                m_r <= $unsigned($signed(dividend) % $signed(divisor));
            end else begin
                m_q <= dividend / divisor;
                m_r <= dividend % divisor;
            end
        end
    end

    // Divider handshake monitor
    int   hs_cnt;
    logic hs_signed, hs_word;
    always @(posedge clk) begin
        if (rst_n && div_valid && div_ready) begin
            hs_cnt    <= hs_cnt + 1;
            hs_signed <= div_signed;
            hs_word   <= divw;
        end
    end

    int passes;
    int checks;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request with res_ready high and collect its result
    task automatic run_op(input logic [1:0] op, input logic word,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] tag,
                          output logic [63:0] data, output logic [4:0] rtag,
                          output int lat, output int nissue);
        int n0;
        n0        = hs_cnt;
        res_ready = 1'b1;
        req_valid = 1'b1;
        req_op    = op;
        req_word  = word;
        req_src1  = a;
        req_src2  = b;
        req_tag   = tag;
        step();
        req_valid = 1'b0;
        lat       = 1;
        while (!res_valid && lat < 50) begin
            step();
            lat = lat + 1;
        end
        data = res_data;
        rtag = res_tag;
        step();
        nissue = hs_cnt - n0;
    endtask

    logic [63:0] d;
    logic [4:0]  t;
    int          lat, ni;

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_word  = 1'b0;
        req_src1  = '0;
        req_src2  = '0;
        req_tag   = '0;
        res_ready = 1'b1;
        hs_cnt    = 0;
        hs_signed = 1'b0;
        hs_word   = 1'b0;
        passes    = 0;
        checks    = 0;

        // Reset values
        #12;
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_div_valid", 64'(div_valid), 64'd0);
        chk("rst_res_data", res_data, 64'd0);
        chk("rst_dividend", dividend, 64'd0);
        #10;
        rst_n = 1'b1;
        step();
        chk("rst_req_ready", 64'(req_ready), 64'd1);

        // DIV -7 / 2 through the divider
        run_op(2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3, d, t, lat, ni);
        chk("div_m7_data", d, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div_m7_tag", 64'(t), 64'd3);
        chk("div_m7_issues", 64'(ni), 64'd1);
        chk("div_m7_signed", 64'(hs_signed), 64'd1);
        chk("div_m7_word", 64'(hs_word), 64'd0);

        // Divide by zero
        run_op(2'd3, 1'b0, 64'h1234, 64'd0, 5'd4, d, t, lat, ni);
        chk("remu_z_data", d, 64'h1234);
        chk("remu_z_lat", 64'(lat), 64'd1);
        chk("remu_z_issues", 64'(ni), 64'd0);
        run_op(2'd1, 1'b0, 64'h1234, 64'd0, 5'd5, d, t, lat, ni);
        chk("divu_z_data", d, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("divu_z_issues", 64'(ni), 64'd0);

        // W-form signed overflow
        run_op(2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, d, t, lat, ni);
        chk("divw_ovf_data", d, 64'hFFFF_FFFF_8000_0000);
        chk("divw_ovf_issues", 64'(ni), 64'd0);
        run_op(2'd2, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, d, t, lat, ni);
        chk("remw_ovf_data", d, 64'd0);

        // Reuse buffer
        run_op(2'd0, 1'b0, 64'd100, 64'd7, 5'd8, d, t, lat, ni);
        chk("div_100_7", d, 64'd14);
        chk("div_100_7_issues", 64'(ni), 64'd1);
        run_op(2'd2, 1'b0, 64'd100, 64'd7, 5'd9, d, t, lat, ni);
        chk("rem_100_7_hit", d, 64'd2);
        chk("rem_100_7_lat", 64'(lat), 64'd1);
        chk("rem_100_7_issues", 64'(ni), 64'd0);
        run_op(2'd2, 1'b0, 64'd100, 64'd8, 5'd10, d, t, lat, ni);
        chk("rem_100_8_miss", d, 64'd4);
        chk("rem_100_8_issues", 64'(ni), 64'd1);

        // Flush while waiting on the divider
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_word  = 1'b0;
        req_src1  = 64'd50;
        req_src2  = 64'd3;
        req_tag   = 5'd11;
        step();
        req_valid = 1'b0;
        chk("fl_issue_valid", 64'(div_valid), 64'd1);
        step();
        chk("fl_wait_valid", 64'(div_valid), 64'd0);
        flush = 1'b1;
        #1;
        chk("fl_div_flush", 64'(div_flush), 64'd1);
        chk("fl_req_ready", 64'(req_ready), 64'd0);
        step();
        flush = 1'b0;
        #1;
        chk("fl_div_flush_off", 64'(div_flush), 64'd0);
        chk("fl_idle_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("fl_no_res", 64'(res_valid), 64'd0);
            step();
        end
        // Earlier buffer entry survives the aborted op
        run_op(2'd0, 1'b0, 64'd100, 64'd8, 5'd12, d, t, lat, ni);
        chk("fl_keep_hit", d, 64'd12);
        chk("fl_keep_issues", 64'(ni), 64'd0);
        run_op(2'd1, 1'b0, 64'd9, 64'd3, 5'd13, d, t, lat, ni);
        chk("divu_9_3", d, 64'd3);
        chk("divu_9_3_issues", 64'(ni), 64'd1);

        // Result back-pressure
        res_ready = 1'b0;
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_src1  = 64'd9;
        req_src2  = 64'd3;
        req_tag   = 5'd14;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(res_valid), 64'd1);
            chk("bp_data", res_data, 64'd3);
            chk("bp_tag", 64'(res_tag), 64'd14);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            step();
        end
        res_ready = 1'b1;
        chk("bp_last_valid", 64'(res_valid), 64'd1);
        step();
        chk("bp_released", 64'(res_valid), 64'd0);
        chk("bp_ready_again", 64'(req_ready), 64'd1);

        // Asynchronous reset during WAIT
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_src1  = 64'd100;
        req_src2  = 64'd9;
        req_tag   = 5'd15;
        step();
        req_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_dividend", dividend, 64'd0);
        chk("ar_res_data", res_data, 64'd0);
        chk("ar_res_tag", 64'(res_tag), 64'd0);
        chk("ar_div_signed", 64'(div_signed), 64'd0);
        #3;
        rst_n = 1'b1;
        step();
        // Buffer cleared by reset: same operands must go to the divider
        run_op(2'd1, 1'b0, 64'd9, 64'd3, 5'd16, d, t, lat, ni);
        chk("ar_divu_9_3", d, 64'd3);
        chk("ar_divu_issues", 64'(ni), 64'd1);
        chk("ar_divu_tag", 64'(t), 64'd16);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22050133_div_issue.md
Name: ysyx_22050133_div_issue

Overview:
- Initiator side of the divider handshake, between the EXU M-extension decode and the multi-cycle divider.
- Accepts DIV/DIVU/REM/REMU and their W forms and resolves RISC-V special cases locally: divide-by-zero and signed overflow.
- Drives the divider's valid/ready/flush interface and selects quotient or remainder, sign-extending W results.
- Returns the result on a valid/ready port, with a one-entry reuse buffer so a DIV/REM pair on the same operands skips the divider.

Parameters:
XLEN, 64, operand/result width
TAG_W, 5, destination tag width carried with each request
REUSE_EN, 1, enables the last-result reuse buffer (0 = every non-special op goes to divider)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  cancel any in-flight op
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_op  in  2  0=DIV 1=DIVU 2=REM 3=REMU
req_word  in  1  W-form (32-bit) op
req_src1  in  XLEN  dividend
req_src2  in  XLEN  divisor
req_tag  in  TAG_W  destination tag
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_data  out  XLEN  result
res_tag  out  TAG_W  tag of result
div_valid  out  1  to divider: operands valid
div_ready  in  1  divider idle
div_flush  out  1  to divider: cancel
divw  out  1  to divider: 32-bit op
div_signed  out  1  to divider: signed op
dividend  out  XLEN  to divider
divisor  out  XLEN  to divider
div_out_valid  in  1  divider result valid (level; stays high while divider idle)
quotient  in  XLEN  divider quotient
remainder  in  XLEN  divider remainder

Behaviour:
- Reset (rst_n low, async): state IDLE, reuse buffer invalid.
  - Outputs: res_valid=0, res_data=0, res_tag=0, div_valid=0, div_flush=0, divw=0, div_signed=0, dividend=0, divisor=0.
  - req_ready=1 once rst_n is high.
- States: IDLE, ISSUE, WAIT, DONE. req_ready = (state==IDLE) & ~flush.
- IDLE, on accept: register op, word, src1, src2 and tag.
  - Effective operands: W ops use src[31:0], sign-extended if signed, zero-extended if unsigned.
  - Classify:
    - divisor==0: quotient = all ones, remainder = dividend.
    - signed overflow (dividend = most-negative of the width, divisor = -1): quotient = dividend, remainder = 0.
    - reuse hit (REUSE_EN, buffer valid, identical src1/src2/signedness/word): stored quotient/remainder.
  - Special case or hit → DONE next cycle, 1-cycle latency.
  - Otherwise → ISSUE.
- ISSUE: div_valid=1, with dividend/divisor/divw/div_signed held stable from registers.
  - On div_valid&div_ready → WAIT next cycle; div_valid deasserts that same next cycle.
- WAIT: sample div_out_valid only in this state.
  - On div_out_valid: capture the selected value and load the reuse buffer (operands, signedness, word, quotient, remainder) → DONE.
- Result select: REM/REMU takes the remainder, otherwise the quotient.
  - W ops: res_data = {{32{v[31]}}, v[31:0]}, for DIVUW/REMUW too.
- DONE: res_valid=1; res_data/res_tag held stable until res_valid&res_ready → IDLE.
  - No new request is accepted in the handshake cycle; minimum 2 cycles per op.
- flush (any state): next state IDLE; res_valid=0 next cycle.
  - div_flush = flush & (state==ISSUE | state==WAIT), combinational.
  - A request presented with flush is not accepted.
  - The reuse buffer is not updated by an aborted op; an existing valid entry is kept.
- Reset mid-operation: immediate return to reset values. The divider is reset separately.

Test Plan:
- DIV, word=0: src1=0xFFFF_FFFF_FFFF_FFF9 (-7), src2=2 → one div_valid handshake with div_signed=1, divw=0; res_data=0xFFFF_FFFF_FFFF_FFFD and res_tag matches.
- REMU: src1=0x1234, src2=0 → res_valid one cycle after accept, res_data=0x1234, div_valid never asserted; DIVU same operands → 0xFFFF_FFFF_FFFF_FFFF.
- DIVW: src1=0x0000_0000_8000_0000, src2=0xFFFF_FFFF_FFFF_FFFF → res_data=0xFFFF_FFFF_8000_0000, no divider use; REMW same operands → 0.
- DIV 100,7 then REM 100,7 → first returns 14 via divider; second returns 2 one cycle after accept with no div_valid; REM 100,8 misses and uses the divider → 4.
- flush asserted in WAIT → div_flush pulses one cycle, state IDLE, no res_valid; next DIVU 9,3 → 3. Async rst_n low during WAIT → all outputs zero immediately.
- res_ready held low 5 cycles in DONE → res_valid, res_data and res_tag stable; req_ready=0 throughout; accepted on the cycle res_ready rises.
